vga_pixel_engine: RTL and testbench

VGA_PIXEL_ENGINE -- requirements
Module: vga_pixel_engine

---
 rtl/vga_pixel_engine.sv | 133 +++++++++++++
 tb/tb_vga_pixel_engine.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_engine.sv
// Pixel engine: tracks the raster position from the timing generator's enable,
// draws a selectable background pattern, overlays layers and registers the result.
module vga_pixel_engine #(
  parameter int P_DISPLAY_X = 1024,
  parameter int P_DISPLAY_Y = 768,
  parameter int P_CW        = 11,
  parameter int P_LAYERS    = 2,
  parameter int P_BAR_W     = 128,
  parameter int P_CHK_SHIFT = 5
) (
  input  logic                   VGA_CLK,
  input  logic                   RST_N,
  input  logic                   VGA_IF_RGBEN,
  input  logic [1:0]             MODE,
  input  logic [P_LAYERS-1:0]    LAYER_EN,
  input  logic [24*P_LAYERS-1:0] LAYER_RGB,
  output logic [P_CW-1:0]        CUR_X,
  output logic [P_CW-1:0]        CUR_Y,
  output logic                   SOF,
  output logic                   EOL,
  output logic [7:0]             FRAME_CNT,
  output logic                   RGB_VALID,
  output logic [23:0]            VGA_BUF_RGB
);

  localparam logic [P_CW-1:0] X_LAST = P_CW'(P_DISPLAY_X - 1);
  localparam logic [P_CW-1:0] Y_LAST = P_CW'(P_DISPLAY_Y - 1);

  logic            en_d1;
  logic [P_CW-1:0] cur_x_reg;
  logic [P_CW-1:0] cur_y_reg;
  logic [P_CW-1:0] cur_x_next;
  logic [P_CW-1:0] cur_y_next;
  logic [7:0]      frame_cnt_reg;
  logic [1:0]      mode_reg;
  logic            rgb_valid_reg;
  logic [23:0]     rgb_reg;

  logic            x_last;
  logic            y_last;
  logic            frame_wrap;
  logic [2:0]      bar_idx;
  logic            chk_bit;
  logic [23:0]     bar_rgb;
  logic [23:0]     bg_rgb;
  logic [23:0]     comp_rgb;
  logic [23:0]     layer_pix [P_LAYERS];

  // Raster position: advances only on cycles that carry a pixel, so blanking
  // gaps simply freeze it.
  always_comb begin
    x_last     = (cur_x_reg == X_LAST);
    y_last     = (cur_y_reg == Y_LAST);
    frame_wrap = en_d1 & x_last & y_last;
    cur_x_next = cur_x_reg + 1'b1;
    cur_y_next = cur_y_reg;
    if (x_last) begin
      cur_x_next = '0;
      cur_y_next = y_last ? '0 : cur_y_reg + 1'b1;
    end
  end

  always_ff @(posedge VGA_CLK or posedge RST_N) begin
    if (RST_N) begin
      en_d1         <= 1'b0;
      cur_x_reg     <= '0;
      cur_y_reg     <= '0;
      frame_cnt_reg <= '0;
      mode_reg      <= '0;
      rgb_valid_reg <= 1'b0;
      rgb_reg       <= '0;
    end else begin
      en_d1         <= VGA_IF_RGBEN;
      rgb_valid_reg <= en_d1;
      rgb_reg       <= en_d1 ? comp_rgb : 24'h000000;
      if (en_d1) begin
        cur_x_reg <= cur_x_next;
        cur_y_reg <= cur_y_next;
      end
      // Mode is latched only at the frame boundary so a frame is never mixed.
      if (frame_wrap) begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
        mode_reg      <= MODE;
      end
    end
  end

  // Background pattern generation
  always_comb begin
    bar_idx = 3'(32'(cur_x_reg) / 32'(P_BAR_W));
    chk_bit = 1'(32'(cur_x_reg) >> P_CHK_SHIFT) ^ 1'(32'(cur_y_reg) >> P_CHK_SHIFT);
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    case (mode_reg)
      2'd0:    bg_rgb = 24'hFFFFFF;
      2'd1:    bg_rgb = bar_rgb;
      2'd2:    bg_rgb = chk_bit ? 24'h000000 : 24'hFFFFFF;
      default: bg_rgb = {8'(cur_x_reg), 8'(cur_y_reg), frame_cnt_reg};
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < P_LAYERS; gi++) begin : g_layer
      assign layer_pix[gi] = LAYER_RGB[24*gi +: 24];
    end
  endgenerate

  // Later (higher-index) layers overwrite earlier ones, giving top-most priority.
  always_comb begin
    comp_rgb = bg_rgb;
    for (int i = 0; i < P_LAYERS; i++) begin
      if (LAYER_EN[i]) comp_rgb = layer_pix[i];
    end
  end

  assign CUR_X       = cur_x_reg;
  assign CUR_Y       = cur_y_reg;
  assign SOF         = en_d1 & (cur_x_reg == '0) & (cur_y_reg == '0);
  assign EOL         = en_d1 & x_last;
  assign FRAME_CNT   = frame_cnt_reg;
  assign RGB_VALID   = rgb_valid_reg;
  assign VGA_BUF_RGB = rgb_reg;

endmodule

// File: tb/tb_vga_pixel_engine.sv
// Directed bench: a 5x4 instance for raster/strobe behaviour and a 1024x4
// instance for patterns, mode latching, layering and mid-frame reset.
module tb_vga_pixel_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [1:0]  layer_en = 2'b00;
  logic [47:0] layer_rgb = {24'h123456, 24'hABCDEF};

  logic [10:0] s_x, s_y, b_x, b_y;
  logic        s_sof, s_eol, s_valid, b_sof, b_eol, b_valid;
  logic [7:0]  s_frame, b_frame;
  logic [23:0] s_rgb, b_rgb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_pixel_engine #(.P_DISPLAY_X(5), .P_DISPLAY_Y(4)) dut_s (
    .VGA_CLK(clk), .RST_N(rst), .VGA_IF_RGBEN(en), .MODE(mode),
    .LAYER_EN(layer_en), .LAYER_RGB(layer_rgb),
    .CUR_X(s_x), .CUR_Y(s_y), .SOF(s_sof), .EOL(s_eol),
    .FRAME_CNT(s_frame), .RGB_VALID(s_valid), .VGA_BUF_RGB(s_rgb));

  vga_pixel_engine #(.P_DISPLAY_X(1024), .P_DISPLAY_Y(4)) dut_b (
    .VGA_CLK(clk), .RST_N(rst), .VGA_IF_RGBEN(en), .MODE(mode),
    .LAYER_EN(layer_en), .LAYER_RGB(layer_rgb),
    .CUR_X(b_x), .CUR_Y(b_y), .SOF(b_sof), .EOL(b_eol),
    .FRAME_CNT(b_frame), .RGB_VALID(b_valid), .VGA_BUF_RGB(b_rgb));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pix(int f, int y, int x);
    return f * 4096 + y * 1024 + x;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       gap_en [8] = '{1, 1, 0, 0, 1, 0, 0, 0};
    int         gap_x  [8] = '{0, 1, 2, 2, 2, 3, 3, 3};
    logic       gap_v  [8] = '{0, 1, 1, 0, 0, 1, 0, 0};
    int         q;

    // Reset state, with enable already high to show strobes stay low
    en = 1'b1;
    repeat (2) tick();
    check_val("rst_x", 32'(s_x), 0);
    check_val("rst_y", 32'(s_y), 0);
    check_val("rst_sof", 32'(s_sof), 0);
    check_val("rst_eol", 32'(s_eol), 0);
    check_val("rst_frame", 32'(s_frame), 0);
    check_val("rst_valid", 32'(s_valid), 0);
    check_val("rst_rgb", 32'(s_rgb), 0);
    check_val("rst_b_valid", 32'(b_valid), 0);

    // 5x4 raster with enable held high, mode 0
    rst = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      tick();
      check_val($sformatf("s_x_%0d", i), 32'(s_x), 32'(i % 5));
      check_val($sformatf("s_y_%0d", i), 32'(s_y), 32'((i / 5) % 4));
      check_val($sformatf("s_eol_%0d", i), 32'(s_eol), 32'(i % 5 == 4));
      check_val($sformatf("s_valid_%0d", i), 32'(s_valid), 32'(i >= 1));
      if (i >= 1) check_val($sformatf("s_rgb_%0d", i), 32'(s_rgb), 32'h00FFFFFF);
      if (i == 0 || i == 20) check_val($sformatf("s_sof_%0d", i), 32'(s_sof), 1);
      if (i == 20) check_val("s_frame_after_20", 32'(s_frame), 1);
    end

    // Enable gap: position holds, valid follows two clocks later
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
    for (int m = 0; m < 8; m++) begin
      en = gap_en[m];
      tick();
      check_val($sformatf("gap_x_%0d", m), 32'(s_x), 32'(gap_x[m]));
      check_val($sformatf("gap_valid_%0d", m), 32'(s_valid), 32'(gap_v[m]));
      check_val($sformatf("gap_rgb_%0d", m), 32'(s_rgb), gap_v[m] ? 32'h00FFFFFF : 32'h0);
    end

    // Long run on the 1024x4 instance: frames 0..3 with scheduled mode/layer changes
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 0; k <= pix(3, 2, 500); k++) begin
      tick();
      if (k == pix(0, 3, 10))  mode = 2'd2;
      if (k == pix(1, 1, 0))   mode = 2'd1;
      if (k == pix(2, 1, 500)) mode = 2'd3;
      layer_en = (k == pix(2, 1, 1000)) ? 2'b11 : (k == pix(2, 1, 1001)) ? 2'b01 : 2'b00;
      if (k == pix(1, 0, 0)) begin
        check_val("f1_frame", 32'(b_frame), 1);
        check_val("f1_sof", 32'(b_sof), 1);
      end
      if (k == pix(2, 0, 1023)) check_val("f2_eol", 32'(b_eol), 1);
      if (k == pix(3, 0, 0)) check_val("f3_frame", 32'(b_frame), 3);
      q = k - 1;
      if (q == pix(0, 3, 40))    check_val("hold_40_3", 32'(b_rgb), 32'h00FFFFFF);
      if (q == pix(0, 3, 1023))  check_val("hold_1023_3", 32'(b_rgb), 32'h00FFFFFF);
      if (q == pix(1, 0, 0))     check_val("chk_0_0", 32'(b_rgb), 32'h00FFFFFF);
      if (q == pix(1, 0, 32))    check_val("chk_32_0", 32'(b_rgb), 32'h0);
      if (q == pix(1, 0, 64))    check_val("chk_64_0", 32'(b_rgb), 32'h00FFFFFF);
      if (q == pix(1, 1, 32))    check_val("chk_32_1", 32'(b_rgb), 32'h0);
      if (q == pix(2, 0, 0))     check_val("bar_0", 32'(b_rgb), 32'h00FFFFFF);
      if (q == pix(2, 0, 128))   check_val("bar_128", 32'(b_rgb), 32'h00FFFF00);
      if (q == pix(2, 0, 300))   check_val("bar_300", 32'(b_rgb), 32'h0000FFFF);
      if (q == pix(2, 0, 768))   check_val("bar_768", 32'(b_rgb), 32'h000000FF);
      if (q == pix(2, 0, 895))   check_val("bar_895", 32'(b_rgb), 32'h000000FF);
      if (q == pix(2, 0, 896))   check_val("bar_896", 32'(b_rgb), 32'h0);
      if (q == pix(2, 0, 1023))  check_val("bar_1023", 32'(b_rgb), 32'h0);
      if (q == pix(2, 1, 1000))  check_val("layer_11", 32'(b_rgb), 32'h00123456);
      if (q == pix(2, 1, 1001))  check_val("layer_01", 32'(b_rgb), 32'h00ABCDEF);
      if (q == pix(2, 1, 1002))  check_val("layer_00", 32'(b_rgb), 32'h0);
      if (q == pix(3, 0, 255))   check_val("grad_255_0", 32'(b_rgb), 32'h00FF0003);
      if (q == pix(3, 0, 256))   check_val("grad_256_0", 32'(b_rgb), 32'h00000003);
      if (q == pix(3, 2, 5))     check_val("grad_5_2", 32'(b_rgb), 32'h00050203);
    end

    // Asynchronous reset mid-frame at (500,2)
    check_val("pre_rst_x", 32'(b_x), 500);
    check_val("pre_rst_y", 32'(b_y), 2);
    #2 rst = 1'b1;
    #1;
    check_val("arst_x", 32'(b_x), 0);
    check_val("arst_y", 32'(b_y), 0);
    check_val("arst_sof", 32'(b_sof), 0);
    check_val("arst_eol", 32'(b_eol), 0);
    check_val("arst_frame", 32'(b_frame), 0);
    check_val("arst_valid", 32'(b_valid), 0);
    check_val("arst_rgb", 32'(b_rgb), 0);
    #1 rst = 1'b0;
    tick();
    check_val("post_rst_x", 32'(b_x), 0);
    check_val("post_rst_y", 32'(b_y), 0);
    check_val("post_rst_sof", 32'(b_sof), 1);
    check_val("post_rst_frame", 32'(b_frame), 0);
    check_val("post_rst_valid", 32'(b_valid), 0);
    tick();
    check_val("post_rst_valid2", 32'(b_valid), 1);
    check_val("post_rst_rgb", 32'(b_rgb), 32'h00FFFFFF);
    en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
